// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle for the digit-serial BCD adder.
// The master side drives the request; the slave side (the adder) returns status and result.
interface bcd_serial_adder_if #(
   parameter int NDIG = 2
);
   logic                  START;
   logic                  MODE;
   logic                  CIN;
   logic [4*NDIG-1:0]     A;
   logic [4*NDIG-1:0]     B;
   logic                  BUSY;
   logic                  DONE;
   logic                  ERR;
   logic [4*NDIG+3:0]     SUM;
   logic [7*NDIG+6:0]     HEX;

   modport master (
      output START, MODE, CIN, A, B,
      input  BUSY, DONE, ERR, SUM, HEX
   );

   modport slave (
      input  START, MODE, CIN, A, B,
      output BUSY, DONE, ERR, SUM, HEX
   );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, LSD first, one digit per clock, with add/accumulate modes,
// non-BCD operand detection and a 7-segment code per result digit.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for START; operands latched on the accepting edge
// S_ADD   | one BCD digit per cycle into the shadow register
// S_FAULT | operand had a digit > 9; report ERR, leave SUM untouched
module bcd_serial_adder #(
   parameter int NDIG           = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic              CLOCK_50,
   input logic              RESET_N,
   bcd_serial_adder_if.slave bus
);
   localparam int W  = 4 * NDIG;
   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    r_q, r_d;
   logic            c_q, c_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W+3:0]    sum_q, sum_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic [4:0]      t;
   logic [3:0]      r_k;
   logic            c_k;
   logic [W+3:0]    r_cat;
   logic [W-1:0]    r_next;

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return SEG_ACTIVE_LOW ? s : ~s;
   endfunction

   // Digit slice: BCD correction by +6 wraps modulo 16 when the 5-bit sum exceeds 9.
   always_comb begin
      t      = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, c_q};
      c_k    = (t > 5'd9);
      r_k    = c_k ? (t[3:0] + 4'd6) : t[3:0];
      r_cat  = {r_k, r_q};
      r_next = r_cat[W+3:4];
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               a_d   = bus.A;
               b_d   = bus.MODE ? sum_q[W-1:0] : bus.B;
               c_d   = bus.CIN;
               r_d   = '0;
               cnt_d = CW'(NDIG - 1);
               if (has_bad_digit(bus.A) || (!bus.MODE && has_bad_digit(bus.B)))
                  state_d = S_FAULT;
               else
                  state_d = S_ADD;
            end
         end
         S_ADD: begin
            a_d = a_q >> 4;
            b_d = b_q >> 4;
            r_d = r_next;
            c_d = c_k;
            if (cnt_q == '0) begin
               sum_d   = {3'b000, c_k, r_next};
               done_d  = 1'b1;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_FAULT: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.BUSY = (state_q != S_IDLE);
   assign bus.DONE = done_q;
   assign bus.ERR  = err_q;
   assign bus.SUM  = sum_q;

   for (genvar i = 0; i <= NDIG; i++) begin : g_hex
      assign bus.HEX[7*i +: 7] = seg7(sum_q[4*i +: 4]);
   end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench: a 2-digit adder for the main scenarios plus a 1-digit adder
// swept over every digit pair against a reference sum.
module tb_bcd_serial_adder;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   bcd_serial_adder_if #(.NDIG(2)) bus2 ();
   bcd_serial_adder_if #(.NDIG(1)) bus1 ();

   bcd_serial_adder #(.NDIG(2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus2)
   );

   bcd_serial_adder #(.NDIG(1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus1)
   );

   localparam logic [6:0]  SEG_0 = 7'b1000000;
   localparam logic [6:0]  SEG_1 = 7'b1111001;
   localparam logic [6:0]  SEG_6 = 7'b0000010;
   localparam logic [6:0]  SEG_8 = 7'b0000000;
   localparam logic [6:0]  SEG_9 = 7'b0010000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request on the 2-digit adder; lat = cycles from the START edge to DONE, -1 on timeout.
   task automatic run2(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, output int lat);
      bus2.MODE  = mode;
      bus2.A     = a;
      bus2.B     = b;
      bus2.CIN   = cin;
      bus2.START = 1'b1;
      step();
      bus2.START = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (bus2.DONE === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin, output int lat);
      bus1.MODE  = 1'b0;
      bus1.A     = a;
      bus1.B     = b;
      bus1.CIN   = cin;
      bus1.START = 1'b1;
      step();
      bus1.START = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (bus1.DONE === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus2.START = 1'b1;
      bus2.A = 8'h12; bus2.B = 8'h34; bus2.MODE = 1'b0; bus2.CIN = 1'b0;
      do_reset();
      bus2.START = 1'b0;
      n_checks++;
      if (bus2.SUM !== 12'h000 || bus2.BUSY !== 1'b0 || bus2.DONE !== 1'b0 || bus2.ERR !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: SUM=%h BUSY=%b DONE=%b ERR=%b, want 000 0 0 0",
                  bus2.SUM, bus2.BUSY, bus2.DONE, bus2.ERR);
      end
      n_checks++;
      if (bus2.HEX !== {SEG_0, SEG_0, SEG_0}) begin
         n_errors++;
         $display("FAIL reset_hex: HEX=%b want %b", bus2.HEX, {SEG_0, SEG_0, SEG_0});
      end
      n_checks++;
      if (bus1.SUM !== 8'h00 || bus1.HEX !== {SEG_0, SEG_0}) begin
         n_errors++;
         $display("FAIL reset_dut1: SUM=%h HEX=%b want 00 %b", bus1.SUM, bus1.HEX, {SEG_0, SEG_0});
      end
   endtask

   task automatic test_add();
      bus2.MODE = 1'b0; bus2.A = 8'h39; bus2.B = 8'h47; bus2.CIN = 1'b0;
      bus2.START = 1'b1;
      step();
      bus2.START = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         n_checks++;
         if (bus2.BUSY !== 1'b1 || bus2.DONE !== 1'b0 || bus2.SUM !== 12'h000) begin
            n_errors++;
            $display("FAIL add_busy cycle %0d: BUSY=%b DONE=%b SUM=%h want 1 0 000",
                     i, bus2.BUSY, bus2.DONE, bus2.SUM);
         end
         if (i < 2) step();
      end
      step();
      n_checks++;
      if (bus2.DONE !== 1'b1 || bus2.BUSY !== 1'b0 || bus2.SUM !== 12'h086 || bus2.ERR !== 1'b0) begin
         n_errors++;
         $display("FAIL add_result: DONE=%b BUSY=%b SUM=%h ERR=%b want 1 0 086 0",
                  bus2.DONE, bus2.BUSY, bus2.SUM, bus2.ERR);
      end
      n_checks++;
      if (bus2.HEX !== {SEG_0, SEG_8, SEG_6}) begin
         n_errors++;
         $display("FAIL add_hex: HEX=%b want %b", bus2.HEX, {SEG_0, SEG_8, SEG_6});
      end
      step();
      n_checks++;
      if (bus2.DONE !== 1'b0 || bus2.SUM !== 12'h086) begin
         n_errors++;
         $display("FAIL add_done_pulse: DONE=%b SUM=%h want 0 086", bus2.DONE, bus2.SUM);
      end
   endtask

   task automatic test_carry();
      int lat;
      run2(1'b0, 8'h99, 8'h99, 1'b1, lat);
      n_checks++;
      if (lat !== 2 || bus2.SUM !== 12'h199) begin
         n_errors++;
         $display("FAIL carry_sum: lat=%0d SUM=%h want 2 199", lat, bus2.SUM);
      end
      n_checks++;
      if (bus2.HEX[20:14] !== SEG_1 || bus2.HEX[6:0] !== SEG_9) begin
         n_errors++;
         $display("FAIL carry_hex: top=%b low=%b want %b %b", bus2.HEX[20:14], bus2.HEX[6:0], SEG_1, SEG_9);
      end
      run2(1'b0, 8'h00, 8'h00, 1'b0, lat);
      n_checks++;
      if (bus2.SUM !== 12'h000) begin
         n_errors++;
         $display("FAIL zero_sum: SUM=%h want 000", bus2.SUM);
      end
   endtask

   task automatic test_fault();
      int lat;
      run2(1'b0, 8'h39, 8'h47, 1'b0, lat);
      run2(1'b0, 8'h3A, 8'h12, 1'b0, lat);
      n_checks++;
      if (lat !== 1 || bus2.ERR !== 1'b1 || bus2.SUM !== 12'h086) begin
         n_errors++;
         $display("FAIL fault_a: lat=%0d ERR=%b SUM=%h want 1 1 086", lat, bus2.ERR, bus2.SUM);
      end
      // ERR must survive while the next request is still running
      bus2.MODE = 1'b0; bus2.A = 8'h01; bus2.B = 8'h02; bus2.CIN = 1'b0;
      bus2.START = 1'b1;
      step();
      bus2.START = 1'b0;
      n_checks++;
      if (bus2.ERR !== 1'b1 || bus2.BUSY !== 1'b1) begin
         n_errors++;
         $display("FAIL err_sticky: ERR=%b BUSY=%b want 1 1", bus2.ERR, bus2.BUSY);
      end
      step();
      step();
      n_checks++;
      if (bus2.DONE !== 1'b1 || bus2.ERR !== 1'b0 || bus2.SUM !== 12'h003) begin
         n_errors++;
         $display("FAIL err_clear: DONE=%b ERR=%b SUM=%h want 1 0 003", bus2.DONE, bus2.ERR, bus2.SUM);
      end
      run2(1'b0, 8'h12, 8'hF0, 1'b0, lat);
      n_checks++;
      if (lat !== 1 || bus2.ERR !== 1'b1 || bus2.SUM !== 12'h003) begin
         n_errors++;
         $display("FAIL fault_b: lat=%0d ERR=%b SUM=%h want 1 1 003", lat, bus2.ERR, bus2.SUM);
      end
      run2(1'b1, 8'h10, 8'hFF, 1'b0, lat);
      n_checks++;
      if (lat !== 2 || bus2.ERR !== 1'b0 || bus2.SUM !== 12'h013) begin
         n_errors++;
         $display("FAIL accum_ignores_b: lat=%0d ERR=%b SUM=%h want 2 0 013", lat, bus2.ERR, bus2.SUM);
      end
   endtask

   task automatic test_accumulate();
      logic [11:0] exp_sum [4];
      int lat;
      exp_sum[0] = 12'h045; exp_sum[1] = 12'h090; exp_sum[2] = 12'h135; exp_sum[3] = 12'h080;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run2(1'b1, 8'h45, 8'h99, 1'b0, lat);
         n_checks++;
         if (lat !== 2 || bus2.SUM !== exp_sum[i] || bus2.ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL accumulate[%0d]: lat=%0d SUM=%h ERR=%b want 2 %h 0",
                     i, lat, bus2.SUM, bus2.ERR, exp_sum[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bus2.MODE = 1'b0; bus2.A = 8'h11; bus2.B = 8'h22; bus2.CIN = 1'b0;
      bus2.START = 1'b1;
      step();
      step();
      step();
      n_checks++;
      if (bus2.DONE !== 1'b1 || bus2.SUM !== 12'h033) begin
         n_errors++;
         $display("FAIL b2b_first: DONE=%b SUM=%h want 1 033", bus2.DONE, bus2.SUM);
      end
      bus2.A = 8'h01; bus2.B = 8'h01;
      step();
      bus2.START = 1'b0;
      n_checks++;
      if (bus2.BUSY !== 1'b1 || bus2.DONE !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_accept: BUSY=%b DONE=%b want 1 0", bus2.BUSY, bus2.DONE);
      end
      step();
      step();
      n_checks++;
      if (bus2.DONE !== 1'b1 || bus2.SUM !== 12'h002) begin
         n_errors++;
         $display("FAIL b2b_second: DONE=%b SUM=%h want 1 002", bus2.DONE, bus2.SUM);
      end
   endtask

   task automatic test_busy_ignore();
      int dones;
      step();
      bus2.MODE = 1'b0; bus2.A = 8'h25; bus2.B = 8'h25; bus2.CIN = 1'b0;
      bus2.START = 1'b1;
      step();
      bus2.START = 1'b1; bus2.A = 8'h77;
      step();
      bus2.START = 1'b0;
      step();
      n_checks++;
      if (bus2.DONE !== 1'b1 || bus2.SUM !== 12'h050) begin
         n_errors++;
         $display("FAIL busy_ignore_done: DONE=%b SUM=%h want 1 050", bus2.DONE, bus2.SUM);
      end
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus2.DONE === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 0 || bus2.SUM !== 12'h050) begin
         n_errors++;
         $display("FAIL busy_ignore_extra: extra DONEs=%0d SUM=%h want 0 050", dones, bus2.SUM);
      end
      bus2.A = 8'h25; bus2.START = 1'b1;
      step();
      bus2.START = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_checks++;
      if (bus2.BUSY !== 1'b0 || bus2.SUM !== 12'h000 || bus2.DONE !== 1'b0
          || bus2.HEX !== {SEG_0, SEG_0, SEG_0}) begin
         n_errors++;
         $display("FAIL reset_mid_add: BUSY=%b SUM=%h DONE=%b HEX=%b want 0 000 0 zeros",
                  bus2.BUSY, bus2.SUM, bus2.DONE, bus2.HEX);
      end
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus2.DONE === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 0 || bus2.BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_abort: DONEs=%0d BUSY=%b want 0 0", dones, bus2.BUSY);
      end
   endtask

   task automatic test_exhaustive();
      int lat;
      int tsum;
      logic [7:0] exp;
      for (int a = 0; a < 10; a++) begin
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 2; c++) begin
               tsum = a + b + c;
               exp  = 8'((tsum / 10) * 16 + (tsum % 10));
               run1(4'(a), 4'(b), 1'(c), lat);
               n_checks++;
               if (lat !== 1 || bus1.SUM !== exp || bus1.ERR !== 1'b0) begin
                  n_errors++;
                  $display("FAIL digit %0d+%0d+%0d: lat=%0d SUM=%h ERR=%b want 1 %h 0",
                           a, b, c, lat, bus1.SUM, bus1.ERR, exp);
               end
            end
         end
      end
      for (int d = 10; d < 16; d++) begin
         run1(4'(d), 4'd3, 1'b0, lat);
         n_checks++;
         if (lat !== 1 || bus1.ERR !== 1'b1 || bus1.SUM !== 8'h19) begin
            n_errors++;
            $display("FAIL bad_a %0d: lat=%0d ERR=%b SUM=%h want 1 1 19", d, lat, bus1.ERR, bus1.SUM);
         end
         run1(4'd3, 4'(d), 1'b1, lat);
         n_checks++;
         if (lat !== 1 || bus1.ERR !== 1'b1 || bus1.SUM !== 8'h19) begin
            n_errors++;
            $display("FAIL bad_b %0d: lat=%0d ERR=%b SUM=%h want 1 1 19", d, lat, bus1.ERR, bus1.SUM);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus2.START = 1'b0; bus2.MODE = 1'b0; bus2.CIN = 1'b0; bus2.A = '0; bus2.B = '0;
      bus1.START = 1'b0; bus1.MODE = 1'b0; bus1.CIN = 1'b0; bus1.A = '0; bus1.B = '0;
      test_reset();
      test_add();
      test_carry();
      test_fault();
      test_accumulate();
      test_back_to_back();
      test_busy_ignore();
      test_exhaustive();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
